mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 106 ++++++++++
 tb/tb_mem_wb_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline register: captures one instruction per edge,
// drives the register-file write port and keeps one-deep forwarding history.
module mem_wb_stage #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter bit R0_LOCKED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] Rd_addr,
    input  logic [1:0]        WB_sel,
    input  logic [DATA_W-1:0] outputOfALU,
    input  logic [DATA_W-1:0] data_out,
    input  logic [DATA_W-1:0] PC,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd2_valid,
    output logic [ADDR_W-1:0] fwd2_addr,
    output logic [DATA_W-1:0] fwd2_data,
    output logic [31:0]       retired_count
);

    logic              capture;
    logic [DATA_W-1:0] sel_data;

    logic              stage_valid_d, stage_valid_q;
    logic              stage_regwr_d, stage_regwr_q;
    logic [ADDR_W-1:0] stage_addr_d,  stage_addr_q;
    logic [DATA_W-1:0] stage_data_d,  stage_data_q;
    logic              fwd2_valid_d,  fwd2_valid_q;
    logic [ADDR_W-1:0] fwd2_addr_d,   fwd2_addr_q;
    logic [DATA_W-1:0] fwd2_data_d,   fwd2_data_q;
    logic [31:0]       retired_count_d, retired_count_q;

    // Write enable comes only from stage flops, so reset kills it immediately.
    assign wb_en = stage_valid_q & stage_regwr_q
                 & ~(R0_LOCKED & (stage_addr_q == '0));

    always_comb begin
        capture = in_valid & ~stall & ~flush;

        case (WB_sel)
            2'b01:   sel_data = data_out;
            2'b10:   sel_data = PC + DATA_W'(1);
            default: sel_data = outputOfALU;
        endcase

        stage_valid_d   = capture;
        stage_regwr_d   = stage_regwr_q;
        stage_addr_d    = stage_addr_q;
        stage_data_d    = stage_data_q;
        retired_count_d = retired_count_q;

        // The counter advances on the edge that loads a valid slot, so it
        // moves together with the write-back it accounts for.
        if (capture) begin
            stage_regwr_d   = RegWr;
            stage_addr_d    = Rd_addr;
            stage_data_d    = sel_data;
            retired_count_d = retired_count_q + 32'd1;
        end

        fwd2_valid_d = wb_en;
        fwd2_addr_d  = fwd2_addr_q;
        fwd2_data_d  = fwd2_data_q;
        if (wb_en) begin
            fwd2_addr_d = stage_addr_q;
            fwd2_data_d = stage_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q   <= 1'b0;
            stage_regwr_q   <= 1'b0;
            stage_addr_q    <= '0;
            stage_data_q    <= '0;
            fwd2_valid_q    <= 1'b0;
            fwd2_addr_q     <= '0;
            fwd2_data_q     <= '0;
            retired_count_q <= '0;
        end else begin
            stage_valid_q   <= stage_valid_d;
            stage_regwr_q   <= stage_regwr_d;
            stage_addr_q    <= stage_addr_d;
            stage_data_q    <= stage_data_d;
            fwd2_valid_q    <= fwd2_valid_d;
            fwd2_addr_q     <= fwd2_addr_d;
            fwd2_data_q     <= fwd2_data_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign wb_addr       = stage_addr_q;
    assign wb_data       = stage_data_q;
    assign fwd2_valid    = fwd2_valid_q;
    assign fwd2_addr     = fwd2_addr_q;
    assign fwd2_data     = fwd2_data_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, stall, flush, RegWr;
    logic [AW-1:0] Rd_addr;
    logic [1:0]    WB_sel;
    logic [DW-1:0] outputOfALU, data_out, PC;
    logic          wb_en, fwd2_valid;
    logic [AW-1:0] wb_addr, fwd2_addr;
    logic [DW-1:0] wb_data, fwd2_data;
    logic [31:0]   retired_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic wrap_req = 1'b0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .R0_LOCKED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall),
        .flush(flush), .RegWr(RegWr), .Rd_addr(Rd_addr), .WB_sel(WB_sel),
        .outputOfALU(outputOfALU), .data_out(data_out), .PC(PC),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd2_valid(fwd2_valid), .fwd2_addr(fwd2_addr), .fwd2_data(fwd2_data),
        .retired_count(retired_count)
    );

    // Behavioural model: the last accepted instruction, the last performed
    // register write, and a retirement tally.
    logic          m_valid, m_regwr;
    logic [AW-1:0] m_addr, m_fa;
    logic [DW-1:0] m_data, m_fd;
    logic          m_fv;
    logic [31:0]   m_count;

    function automatic logic model_writes();
        return m_valid && m_regwr && (m_addr != 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_regwr = 0; m_addr = 0; m_data = 0;
            m_fv = 0; m_fa = 0; m_fd = 0; m_count = 0;
        end else begin
            if (model_writes()) begin
                m_fa = m_addr;
                m_fd = m_data;
            end
            m_fv = model_writes();
            if (wrap_req) m_count = 32'hFFFF_FFFF;
            if (in_valid && !stall && !flush) begin
                m_valid = 1;
                m_regwr = RegWr;
                m_addr  = Rd_addr;
                case (WB_sel)
                    2'd1:    m_data = data_out;
                    2'd2:    m_data = PC + 1;
                    default: m_data = outputOfALU;
                endcase
                m_count = m_count + 1;
            end else begin
                m_valid = 0;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        cmp("model wb_en",    32'(wb_en),      32'(model_writes()));
        cmp("model wb_addr",  32'(wb_addr),    32'(m_addr));
        cmp("model wb_data",  wb_data,         m_data);
        cmp("model fwd2_v",   32'(fwd2_valid), 32'(m_fv));
        cmp("model fwd2_a",   32'(fwd2_addr),  32'(m_fa));
        cmp("model fwd2_d",   fwd2_data,       m_fd);
        cmp("model count",    retired_count,   m_count);
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, " wb_en"},  32'(wb_en),      0);
        cmp({tag, " wb_addr"},32'(wb_addr),    0);
        cmp({tag, " wb_data"},wb_data,         0);
        cmp({tag, " fwd2_v"}, 32'(fwd2_valid), 0);
        cmp({tag, " fwd2_a"}, 32'(fwd2_addr),  0);
        cmp({tag, " fwd2_d"}, fwd2_data,       0);
        cmp({tag, " count"},  retired_count,   0);
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic rw,
                         input logic [AW-1:0] rd, input logic [1:0] sel,
                         input logic [DW-1:0] alu, input logic [DW-1:0] dout,
                         input logic [DW-1:0] pc);
        in_valid = v; stall = s; flush = f; RegWr = rw; Rd_addr = rd;
        WB_sel = sel; outputOfALU = alu; data_out = dout; PC = pc;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        check_all();
    endtask

    logic [31:0] base_cnt;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        check_zero("reset");
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU write to r3
        drive(1, 0, 0, 1, 3, 2'b00, 32'h0000_1234, 0, 0);
        tick();
        cmp("alu wb_en", 32'(wb_en), 1);
        cmp("alu wb_addr", 32'(wb_addr), 3);
        cmp("alu wb_data", wb_data, 32'h1234);
        cmp("alu count", retired_count, 1);

        // Load then link with PC wrap
        drive(1, 0, 0, 1, 5, 2'b01, 0, 32'hDEAD_BEEF, 0);
        tick();
        cmp("load wb_data", wb_data, 32'hDEAD_BEEF);
        drive(1, 0, 0, 1, 15, 2'b10, 0, 0, 32'hFFFF_FFFF);
        tick();
        cmp("link wb_data", wb_data, 0);
        cmp("link wb_addr", 32'(wb_addr), 15);
        cmp("link fwd2_v", 32'(fwd2_valid), 1);
        cmp("link fwd2_a", 32'(fwd2_addr), 5);
        cmp("link fwd2_d", fwd2_data, 32'hDEAD_BEEF);
        cmp("link count", retired_count, 3);

        // Register 0 write is suppressed but still retires
        drive(1, 0, 0, 1, 0, 2'b00, 32'h55, 0, 0);
        tick();
        cmp("r0 wb_en", 32'(wb_en), 0);
        cmp("r0 count", retired_count, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        cmp("r0 fwd2_v", 32'(fwd2_valid), 0);

        // Stall, flush, both: three bubbles
        base_cnt = retired_count;
        drive(1, 1, 0, 1, 9, 0, 32'h77, 0, 0);
        tick();
        cmp("stall wb_en", 32'(wb_en), 0);
        drive(1, 0, 1, 1, 9, 0, 32'h77, 0, 0);
        tick();
        cmp("flush wb_en", 32'(wb_en), 0);
        drive(1, 1, 1, 1, 9, 0, 32'h77, 0, 0);
        tick();
        cmp("both wb_en", 32'(wb_en), 0);
        cmp("bubble count", retired_count, base_cnt);

        // Counter wrap
        drive(1, 0, 0, 1, 2, 0, 32'h99, 0, 0);
        wrap_req = 1'b1;
        force dut.retired_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count_q;
        tick();
        wrap_req = 1'b0;
        cmp("wrap count", retired_count, 0);

        // Async reset while a write is in flight
        drive(1, 0, 0, 1, 6, 0, 32'hCAFE, 0, 0);
        tick();
        cmp("prereset wb_en", 32'(wb_en), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        check_all();
        drive(1, 0, 0, 1, 7, 0, 32'hA5, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cmp("postreset wb_en", 32'(wb_en), 1);
        cmp("postreset addr", 32'(wb_addr), 7);
        cmp("postreset data", wb_data, 32'hA5);
        cmp("postreset count", retired_count, 1);

        // Randomized traffic with one mid-run async reset
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                  AW'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom);
            if (i == 300) begin
                #1;
                rst_n = 1'b0;
                #1;
                check_zero("rand reset");
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
